fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Y86-64 pipeline fetch controller. Owns the predicted-PC register and drives the PC into the fetch stage. Consumes the decoded fields fetch produces for that PC, plus mispredict (M stage), return (W stage) and load-use hazard information. Produces the next PC, fetch status, and stall/bubble controls for the F, D and E pipeline registers. It sequences fetch through normal run, return wait, halt and fault states.

## Interface
- RESET_PC, 64'd0, PC presented after reset
- IMEM_BYTES, 1024, instruction memory size in bytes; PC+10 > IMEM_BYTES is an address fault
- RET_TIMEOUT, 7, max cycles in RET_WAIT before FAULT
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  out  64  PC driven to fetch (combinational from state and M/W inputs)
- f_icode  in  4  icode fetched at current pc
- f_valC  in  64  constant word of current instruction
- f_valP  in  64  fall-through address of current instruction
- f_instr_valid  in  1  current icode is legal
- f_imem_error  in  1  current pc out of range
- M_icode  in  4  icode in memory stage
- M_cnd  in  1  branch condition of M-stage jXX
- M_valA  in  64  fall-through address of M-stage jXX
- W_icode  in  4  icode in write-back stage
- W_valM  in  64  return address popped by W-stage ret
- load_use  in  1  load-use hazard from the hazard detector
- f_stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
- F_stall, D_stall  out  1  hold F / D pipeline register
- D_bubble, E_bubble  out  1  insert nop into D / E register
- state  out  2  0 RUN, 1 RET_WAIT, 2 HALT, 3 FAULT

## Operation
- Events:
  - mispredict = (M_icode==7 && !M_cnd)
  - ret_done = (W_icode==9)
- PC select, in priority order:
  - mispredict → M_valA
  - ret_done → W_valM
  - otherwise predPC
- Prediction: f_icode ∈ {7 jXX, 8 call} → f_valC; otherwise f_valP.
- RUN:
  - f_imem_error or pc+10 > IMEM_BYTES → FAULT, f_stat=ADR.
  - Otherwise !f_instr_valid → FAULT, f_stat=INS.
  - icode 0 → HALT, f_stat=HLT.
  - icode 9 → RET_WAIT.
  - Otherwise predPC ← prediction.
- RET_WAIT:
  - F_stall=1 and D_bubble=1 every cycle.
  - A counter increments each cycle.
  - ret_done → RUN, predPC ← W_valM's successor prediction, counter cleared.
  - Counter reaching RET_TIMEOUT → FAULT, f_stat=ADR.
- HALT and FAULT:
  - F_stall=1, D_bubble=1, pc frozen.
  - f_stat held at its latched value.
  - Only exits: reset or mispredict.
- Mispredict exits any state:
  - next state RUN.
  - D_bubble=1, E_bubble=1.
  - predPC ← prediction for the instruction at M_valA.
  - The wrong-path halt, ret or fault is cancelled.
- load_use, with no mispredict, in RUN:
  - F_stall=1, D_stall=1, E_bubble=1.
  - predPC and state held.
- Simultaneous events:
  - mispredict + load_use → mispredict wins; D_bubble=E_bubble=1, stalls 0.
  - ret_done + load_use → stall wins; stay in RET_WAIT and re-evaluate next cycle. W_valM is guaranteed stable by the hazard unit.
  - mispredict + ret_done → mispredict wins.
- Width rules:
  - All PC arithmetic is 64-bit unsigned, no wrap detection beyond the IMEM_BYTES check.
  - The pc+10 range check is done in 65 bits.

## Timing
- Reset values while reset=1:
  - state=RUN, predPC=RESET_PC, pc=RESET_PC.
  - f_stat=AOK, F_stall=D_stall=0, D_bubble=E_bubble=1.
  - RET_WAIT counter=0.
- First cycle after reset deasserts: pc=RESET_PC, bubbles=0.
- pc and all stall/bubble outputs are combinational from registered state and same-cycle inputs; no added latency.
- predPC, state, f_stat and the counter update on the rising edge; their effect is visible the cycle after the triggering fetch.
- Mispredict redirect and ret_done redirect take effect in the same cycle, through the pc mux.
- Reset mid-operation, including during RET_WAIT or HALT, returns to RUN at RESET_PC on the next edge.

## Test plan
- Reset and run:
  - Stimulus: hold reset 2 cycles; release with f_icode=3, f_valP=10.
  - Response: pc=0 with D_bubble=E_bubble=1 during reset; pc=10 next cycle, then pc=20 with f_valP=20.
- Jump prediction and mispredict:
  - Stimulus: at pc=0x20, f_icode=7, f_valC=0x100, f_valP=0x29; 3 cycles later M_icode=7, M_cnd=0, M_valA=0x29.
  - Response: pc=0x100 the next cycle; pc=0x29 in the mispredict cycle with D_bubble=E_bubble=1.
- Return:
  - Stimulus: f_icode=9 at pc=0x40; W_icode=9, W_valM=0x55 on the 4th cycle.
  - Response: state=RET_WAIT with F_stall=D_bubble=1 for 3 cycles; pc=0x55 on the 4th cycle; state=RUN after.
- Load-use:
  - Stimulus: load_use=1 for 1 cycle at pc=0x14.
  - Response: pc stays 0x14 two cycles; F_stall=D_stall=E_bubble=1 for exactly one cycle.
  - Stimulus: repeat with a simultaneous mispredict (M_valA=0x30).
  - Response: pc=0x30, stalls 0, both bubbles 1.
- Halt and fault:
  - Stimulus: f_icode=0 at pc=0x18.
  - Response: HALT, f_stat=1, pc=0x18 held for 10 cycles.
  - Stimulus: after reset, pc=0x3FC.
  - Response: FAULT, f_stat=2.
  - Stimulus: an invalid icode after reset.
  - Response: f_stat=3.
- Cancel and timeout:
  - Stimulus: in HALT, mispredict with M_valA=0x60.
  - Response: state=RUN, pc=0x60, f_stat=0.
  - Stimulus: RET_WAIT with no W ret for 7 cycles.
  - Response: FAULT, f_stat=2.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch controller: owns predicted PC, selects fetch PC and sequences
// RUN / RET_WAIT / HALT / FAULT with F/D/E stall and bubble controls.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int unsigned RET_TIMEOUT = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [63:0] pc_o,
    input  logic [3:0]  f_icode_i,
    input  logic [63:0] f_valC_i,
    input  logic [63:0] f_valP_i,
    input  logic        f_instr_valid_i,
    input  logic        f_imem_error_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    input  logic        load_use_i,
    output logic [1:0]  f_stat_o,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_bubble_o,
    output logic [1:0]  state_o
);

    localparam int CW = (RET_TIMEOUT < 2) ? 1 : $clog2(RET_TIMEOUT + 1);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] I_HALT = 4'd0;
    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     pred_q, pred_d;
    logic [1:0]      stat_q, stat_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mispredict, ret_done, addr_fault, frozen;
    logic [63:0]     prediction;
    logic [64:0]     pc_end;

    assign mispredict = (M_icode_i == I_JXX) && !M_cnd_i;
    assign ret_done   = (W_icode_i == I_RET);
    assign frozen     = (state_q == S_HALT) || (state_q == S_FAULT);
    assign prediction = ((f_icode_i == I_JXX) || (f_icode_i == I_CALL)) ? f_valC_i : f_valP_i;

    always_comb begin
        if (reset_i)
            pc_o = RESET_PC;
        else if (mispredict)
            pc_o = M_valA_i;
        else if (ret_done && !frozen)
            pc_o = W_valM_i;
        else
            pc_o = pred_q;
    end

    // Widened so a PC near 2^64 cannot wrap past the range check.
    assign pc_end     = {1'b0, pc_o} + 65'd10;
    assign addr_fault = f_imem_error_i || (pc_end > 65'(IMEM_BYTES));

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        if (mispredict) begin
            state_d = S_RUN;
            pred_d  = prediction;
            stat_d  = STAT_AOK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!load_use_i) begin
                        if (addr_fault) begin
                            state_d = S_FAULT;
                            stat_d  = STAT_ADR;
                            pred_d  = pc_o;
                        end else if (!f_instr_valid_i) begin
                            state_d = S_FAULT;
                            stat_d  = STAT_INS;
                            pred_d  = pc_o;
                        end else if (f_icode_i == I_HALT) begin
                            state_d = S_HALT;
                            stat_d  = STAT_HLT;
                            pred_d  = pc_o;
                        end else if (f_icode_i == I_RET) begin
                            state_d = S_RET_WAIT;
                            pred_d  = pc_o;
                            cnt_d   = '0;
                        end else begin
                            pred_d  = prediction;
                        end
                    end
                end
                S_RET_WAIT: begin
                    if (ret_done && !load_use_i) begin
                        state_d = S_RUN;
                        pred_d  = prediction;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(RET_TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                        stat_d  = STAT_ADR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_RUN;
            pred_q  <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: reset, mispredict, load-use (only while fetch is live), state.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        if (reset_i || mispredict) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
        end else if (load_use_i && !frozen) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
        end else if (frozen || (state_q == S_RET_WAIT && !ret_done)) begin
            F_stall_o  = 1'b1;
            D_bubble_o = 1'b1;
        end
    end

    assign f_stat_o = stat_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; ctl packs {state, f_stat, F_stall, D_stall, D_bubble, E_bubble}.
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] pc_o;
    logic [3:0]  f_icode_i;
    logic [63:0] f_valC_i;
    logic [63:0] f_valP_i;
    logic        f_instr_valid_i;
    logic        f_imem_error_i;
    logic [3:0]  M_icode_i;
    logic        M_cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic        load_use_i;
    logic [1:0]  f_stat_o;
    logic        F_stall_o, D_stall_o, D_bubble_o, E_bubble_o;
    logic [1:0]  state_o;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .pc_o(pc_o),
        .f_icode_i(f_icode_i), .f_valC_i(f_valC_i), .f_valP_i(f_valP_i),
        .f_instr_valid_i(f_instr_valid_i), .f_imem_error_i(f_imem_error_i),
        .M_icode_i(M_icode_i), .M_cnd_i(M_cnd_i), .M_valA_i(M_valA_i),
        .W_icode_i(W_icode_i), .W_valM_i(W_valM_i), .load_use_i(load_use_i),
        .f_stat_o(f_stat_o), .F_stall_o(F_stall_o), .D_stall_o(D_stall_o),
        .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl = {state_o, f_stat_o, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_f(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
        f_icode_i       = icode;
        f_valC_i        = valc;
        f_valP_i        = valp;
        f_instr_valid_i = 1'b1;
        f_imem_error_i  = 1'b0;
    endtask

    task automatic clear_mw();
        M_icode_i  = 4'd1;
        M_cnd_i    = 1'b0;
        M_valA_i   = 64'd0;
        W_icode_i  = 4'd1;
        W_valM_i   = 64'd0;
        load_use_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_mw();
        drive_f(4'd1, 64'd0, 64'd0);
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        clear_mw();
        drive_f(4'd3, 64'd0, 64'd10);
        tick();
        tick();
        checks++; if (pc_o !== 64'd0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc_o); end
        checks++; if (ctl !== 8'b00_00_0011) begin errors++; $display("FAIL reset_ctl got %b exp 00000011", ctl); end
        reset_i = 1'b0;
        settle();
        checks++; if (pc_o !== 64'd0) begin errors++; $display("FAIL first_pc got %0h exp 0", pc_o); end
        checks++; if (ctl !== 8'b00_00_0000) begin errors++; $display("FAIL first_ctl got %b exp 00000000", ctl); end
        tick();
        checks++; if (pc_o !== 64'd10) begin errors++; $display("FAIL run_pc10 got %0h exp a", pc_o); end
        drive_f(4'd3, 64'd0, 64'd20);
        tick();
        checks++; if (pc_o !== 64'd20) begin errors++; $display("FAIL run_pc20 got %0h exp 14", pc_o); end
    endtask

    task automatic test_jump();
        drive_f(4'd3, 64'd0, 64'h20);
        tick();
        checks++; if (pc_o !== 64'h20) begin errors++; $display("FAIL jmp_at got %0h exp 20", pc_o); end
        drive_f(4'd7, 64'h100, 64'h29);
        tick();
        checks++; if (pc_o !== 64'h100) begin errors++; $display("FAIL jmp_pred got %0h exp 100", pc_o); end
        drive_f(4'd3, 64'd0, 64'h10A);
        tick();
        drive_f(4'd3, 64'd0, 64'h114);
        tick();
        M_icode_i = 4'd7; M_cnd_i = 1'b0; M_valA_i = 64'h29;
        drive_f(4'd3, 64'd0, 64'h33);
        settle();
        checks++; if (pc_o !== 64'h29) begin errors++; $display("FAIL mispred_pc got %0h exp 29", pc_o); end
        checks++; if (ctl !== 8'b00_00_0011) begin errors++; $display("FAIL mispred_ctl got %b exp 00000011", ctl); end
        tick();
        clear_mw();
        settle();
        checks++; if (pc_o !== 64'h33) begin errors++; $display("FAIL mispred_next got %0h exp 33", pc_o); end
        M_icode_i = 4'd7; M_cnd_i = 1'b1; M_valA_i = 64'h77;
        settle();
        checks++; if (pc_o !== 64'h33) begin errors++; $display("FAIL taken_pc got %0h exp 33", pc_o); end
        checks++; if (ctl !== 8'b00_00_0000) begin errors++; $display("FAIL taken_ctl got %b exp 00000000", ctl); end
        clear_mw();
    endtask

    task automatic test_return();
        drive_f(4'd3, 64'd0, 64'h40);
        tick();
        checks++; if (pc_o !== 64'h40) begin errors++; $display("FAIL ret_at got %0h exp 40", pc_o); end
        drive_f(4'd9, 64'd0, 64'h41);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (ctl !== 8'b01_00_1010) begin errors++; $display("FAIL ret_wait_ctl cyc %0d got %b exp 01001010", i, ctl); end
            tick();
        end
        W_icode_i = 4'd9; W_valM_i = 64'h55;
        drive_f(4'd3, 64'd0, 64'h5F);
        settle();
        checks++; if (pc_o !== 64'h55) begin errors++; $display("FAIL ret_pc got %0h exp 55", pc_o); end
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ret_state got %0d exp 1", state_o); end
        tick();
        clear_mw();
        settle();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL ret_run got %0d exp 0", state_o); end
        checks++; if (pc_o !== 64'h5F) begin errors++; $display("FAIL ret_succ got %0h exp 5f", pc_o); end
    endtask

    task automatic test_load_use();
        drive_f(4'd3, 64'd0, 64'h14);
        tick();
        load_use_i = 1'b1;
        drive_f(4'd3, 64'd0, 64'h1E);
        settle();
        checks++; if (pc_o !== 64'h14) begin errors++; $display("FAIL lu_pc0 got %0h exp 14", pc_o); end
        checks++; if (ctl !== 8'b00_00_1101) begin errors++; $display("FAIL lu_ctl got %b exp 00001101", ctl); end
        tick();
        load_use_i = 1'b0;
        settle();
        checks++; if (pc_o !== 64'h14) begin errors++; $display("FAIL lu_pc1 got %0h exp 14", pc_o); end
        checks++; if (ctl !== 8'b00_00_0000) begin errors++; $display("FAIL lu_release got %b exp 00000000", ctl); end
        tick();
        checks++; if (pc_o !== 64'h1E) begin errors++; $display("FAIL lu_advance got %0h exp 1e", pc_o); end
        load_use_i = 1'b1;
        M_icode_i = 4'd7; M_cnd_i = 1'b0; M_valA_i = 64'h30;
        drive_f(4'd3, 64'd0, 64'h3A);
        settle();
        checks++; if (pc_o !== 64'h30) begin errors++; $display("FAIL lu_mp_pc got %0h exp 30", pc_o); end
        checks++; if (ctl !== 8'b00_00_0011) begin errors++; $display("FAIL lu_mp_ctl got %b exp 00000011", ctl); end
        tick();
        clear_mw();
        settle();
        checks++; if (pc_o !== 64'h3A) begin errors++; $display("FAIL lu_mp_next got %0h exp 3a", pc_o); end
    endtask

    task automatic test_halt_cancel();
        drive_f(4'd3, 64'd0, 64'h18);
        tick();
        drive_f(4'd0, 64'd0, 64'h19);
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++; if (pc_o !== 64'h18 || ctl !== 8'b10_01_1010) begin
                errors++; $display("FAIL halt_hold cyc %0d got pc %0h ctl %b exp pc 18 ctl 10011010", i, pc_o, ctl);
            end
            tick();
        end
        M_icode_i = 4'd7; M_cnd_i = 1'b0; M_valA_i = 64'h60;
        drive_f(4'd3, 64'd0, 64'h6A);
        settle();
        checks++; if (pc_o !== 64'h60) begin errors++; $display("FAIL cancel_pc got %0h exp 60", pc_o); end
        checks++; if (ctl !== 8'b10_01_0011) begin errors++; $display("FAIL cancel_ctl got %b exp 10010011", ctl); end
        tick();
        clear_mw();
        settle();
        checks++; if (ctl !== 8'b00_00_0000) begin errors++; $display("FAIL cancel_run got %b exp 00000000", ctl); end
        checks++; if (pc_o !== 64'h6A) begin errors++; $display("FAIL cancel_next got %0h exp 6a", pc_o); end
    endtask

    task automatic test_faults();
        do_reset();
        drive_f(4'd3, 64'd0, 64'h3F6);
        tick();
        drive_f(4'd3, 64'd0, 64'h3FC);
        tick();
        checks++; if (pc_o !== 64'h3FC || state_o !== 2'd0) begin
            errors++; $display("FAIL edge_ok got pc %0h state %0d exp pc 3fc state 0", pc_o, state_o);
        end
        drive_f(4'd3, 64'd0, 64'h406);
        tick();
        tick();
        checks++; if (ctl !== 8'b11_10_1010) begin errors++; $display("FAIL adr_ctl got %b exp 11101010", ctl); end
        checks++; if (pc_o !== 64'h3FC) begin errors++; $display("FAIL adr_pc got %0h exp 3fc", pc_o); end
        do_reset();
        drive_f(4'd3, 64'd0, 64'h8);
        f_imem_error_i = 1'b1;
        tick();
        checks++; if (ctl !== 8'b11_10_1010) begin errors++; $display("FAIL imem_err got %b exp 11101010", ctl); end
        do_reset();
        drive_f(4'd3, 64'd0, 64'h8);
        f_instr_valid_i = 1'b0;
        tick();
        checks++; if (ctl !== 8'b11_11_1010) begin errors++; $display("FAIL ins_ctl got %b exp 11111010", ctl); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_f(4'd9, 64'd0, 64'h1);
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL tmo_wait cyc %0d got %0d exp 1", i, state_o); end
            tick();
        end
        checks++; if (ctl !== 8'b11_10_1010) begin errors++; $display("FAIL tmo_fault got %b exp 11101010", ctl); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_f(4'd9, 64'd0, 64'h1);
        tick();
        W_icode_i = 4'd9; W_valM_i = 64'h70; load_use_i = 1'b1;
        drive_f(4'd3, 64'd0, 64'h7A);
        settle();
        checks++; if (ctl !== 8'b01_00_1101) begin errors++; $display("FAIL retlu_ctl got %b exp 01001101", ctl); end
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL retlu_hold got %0d exp 1", state_o); end
        load_use_i = 1'b0;
        tick();
        clear_mw();
        settle();
        checks++; if (state_o !== 2'd0 || pc_o !== 64'h7A) begin
            errors++; $display("FAIL retlu_exit got state %0d pc %0h exp state 0 pc 7a", state_o, pc_o);
        end
        drive_f(4'd9, 64'd0, 64'h7B);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        checks++; if (ctl !== 8'b00_00_0011 || pc_o !== 64'd0) begin
            errors++; $display("FAIL mid_reset got ctl %b pc %0h exp ctl 00000011 pc 0", ctl, pc_o);
        end
        reset_i = 1'b0;
        drive_f(4'd3, 64'd0, 64'h5);
        settle();
        checks++; if (ctl !== 8'b00_00_0000) begin errors++; $display("FAIL mid_reset_run got %b exp 00000000", ctl); end
    endtask

    initial begin
        reset_i = 1'b1;
        clear_mw();
        drive_f(4'd1, 64'd0, 64'd0);
        test_reset();
        test_jump();
        test_return();
        test_load_use();
        test_halt_cancel();
        test_faults();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
